// File: rtl/ic_fill_ctrl.sv
// Instruction-cache line fill controller: accepts a line miss, reads the 32-byte
// line as BEATS sequential memory beats, and returns it with a one-cycle ack.
module ic_fill_ctrl #(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_miss,
    input  logic [31:0]       ic_miss_addr,
    output logic              ic_miss_ack,
    output logic [31:0]       ic_miss_ack_addr,
    output logic [255:0]      ic_fill_data,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              fill_busy
);

    localparam int BEATS = 256 / BEAT_W;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0]      line_addr_r;
    logic [31:0]      line_addr_nxt_s;
    logic [255:0]     data_r;
    logic [255:0]     data_nxt_s;
    logic             mem_req_r;
    logic             ack_r;
    logic             busy_r;
    logic             mem_req_nxt_s;
    logic             ack_nxt_s;
    logic             busy_nxt_s;

    // Byte-offset bits of the miss address never reach the memory side.
    logic unused_offset_s;
    assign unused_offset_s = ^ic_miss_addr[4:0];

    // Next-state, beat counter, line address and line assembly.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        line_addr_nxt_s = line_addr_r;
        data_nxt_s      = data_r;
        case (state_r)
            IDLE: begin
                if (ic_miss) begin
                    line_addr_nxt_s = {ic_miss_addr[31:5], 5'b00000};
                    data_nxt_s      = {256{1'b0}};
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    state_nxt_s     = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DATA: begin
                if (mem_rvalid) begin
                    // Beat n lands in slice n; beat 0 holds the lowest address.
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_r == CNT_W'(b)) begin
                            data_nxt_s[b*BEAT_W +: BEAT_W] = mem_rdata;
                        end else begin
                            data_nxt_s[b*BEAT_W +: BEAT_W] = data_r[b*BEAT_W +: BEAT_W];
                        end
                    end
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(BEATS - 1)) begin
                        state_nxt_s = ACK;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            ACK: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state and registered so they
    // come straight off flops.
    always_comb begin
        mem_req_nxt_s = 1'b0;
        ack_nxt_s     = 1'b0;
        busy_nxt_s    = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                busy_nxt_s = 1'b0;
            end
            REQ: begin
                mem_req_nxt_s = 1'b1;
                busy_nxt_s    = 1'b1;
            end
            DATA: begin
                busy_nxt_s = 1'b1;
            end
            ACK: begin
                ack_nxt_s  = 1'b1;
                busy_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            line_addr_r <= 32'h0000_0000;
            data_r      <= {256{1'b0}};
            mem_req_r   <= 1'b0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            line_addr_r <= line_addr_nxt_s;
            data_r      <= data_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            ack_r       <= ack_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign mem_req          = mem_req_r;
    assign ic_miss_ack      = ack_r;
    assign fill_busy        = busy_r;
    assign mem_addr         = line_addr_r;
    assign ic_miss_ack_addr = line_addr_r;
    assign ic_fill_data     = data_r;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Scoreboard bench for ic_fill_ctrl: three instances (BEAT_W 64, 32, 256) driven
// with directed and random fills; a monitor checks every ack against a line model.
module tb_ic_fill_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         miss_s      [3];
    logic [31:0]  miss_addr_s [3];
    logic         ack_s       [3];
    logic [31:0]  ack_addr_s  [3];
    logic [255:0] fill_s      [3];
    logic         req_s       [3];
    logic [31:0]  maddr_s     [3];
    logic         gnt_s       [3];
    logic         rvalid_s    [3];
    logic [255:0] rdata_s     [3];
    logic         busy_s      [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BW = (g == 0) ? 64 : ((g == 1) ? 32 : 256);
        ic_fill_ctrl #(.BEAT_W(BW)) dut (
            .clk              (clk),
            .rst              (rst),
            .ic_miss          (miss_s[g]),
            .ic_miss_addr     (miss_addr_s[g]),
            .ic_miss_ack      (ack_s[g]),
            .ic_miss_ack_addr (ack_addr_s[g]),
            .ic_fill_data     (fill_s[g]),
            .mem_req          (req_s[g]),
            .mem_addr         (maddr_s[g]),
            .mem_gnt          (gnt_s[g]),
            .mem_rvalid       (rvalid_s[g]),
            .mem_rdata        (rdata_s[g][BW-1:0]),
            .fill_busy        (busy_s[g])
        );
    end

    typedef struct {
        int           inst;
        logic [31:0]  addr;
        logic [255:0] data;
        longint       cyc;
    } exp_t;

    exp_t         sb[$];
    longint       cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [255:0] last_line [3];
    logic         prev_ack  [3];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int beat_w(input int inst);
        case (inst)
            0:       return 64;
            1:       return 32;
            default: return 256;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input int i);
        chk("rst_req",      256'(req_s[i]),      256'(0));
        chk("rst_ack",      256'(ack_s[i]),      256'(0));
        chk("rst_busy",     256'(busy_s[i]),     256'(0));
        chk("rst_mem_addr", 256'(maddr_s[i]),    256'(0));
        chk("rst_ack_addr", 256'(ack_addr_s[i]), 256'(0));
        chk("rst_fill",     fill_s[i],           256'(0));
    endtask

    // Idle cycles with junk grant/beat traffic that must be ignored.
    task automatic idle_noise(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            gnt_s[i]    = 1'($urandom_range(0, 1));
            rvalid_s[i] = 1'($urandom_range(0, 1));
            rdata_s[i]  = rand256();
            @(negedge clk);
            chk("idle_busy", 256'(busy_s[i]), 256'(0));
            chk("idle_hold", fill_s[i], last_line[i]);
        end
        gnt_s[i]    = 1'b0;
        rvalid_s[i] = 1'b0;
    endtask

    // One miss: gnt after gwait REQ cycles, gaps of gmin..gmax between beats.
    // abort_at >= 0 pulses rst after that many beats instead of completing.
    task automatic run_fill(input int i, input logic [31:0] addr, input int gwait,
                            input int gmin, input int gmax, input bit fixed,
                            input bit keep, input logic [31:0] nxt, input int abort_at);
        int           bw, nb, gaps, g;
        logic [255:0] line, beat, mask;
        logic [31:0]  la;
        longint       c0;
        exp_t         e;
        bw   = beat_w(i);
        nb   = 256 / bw;
        la   = {addr[31:5], 5'b00000};
        mask = (bw == 256) ? {256{1'b1}} : ((256'(1) << bw) - 256'(1));
        line = '0;
        gaps = 0;
        miss_s[i]      = 1'b1;
        miss_addr_s[i] = addr;
        c0 = cyc;
        @(negedge clk);
        if (!keep) begin
            miss_s[i]      = 1'b0;
            miss_addr_s[i] = $urandom;
        end
        for (int w = 0; w <= gwait; w++) begin
            chk("req_high", 256'(req_s[i]), 256'(1));
            chk("req_addr", 256'(maddr_s[i]), 256'(la));
            if (w == gwait) begin
                gnt_s[i]    = 1'b1;
                rvalid_s[i] = 1'b0;
            end else begin
                gnt_s[i]    = 1'b0;
                rvalid_s[i] = 1'($urandom_range(0, 1));
                rdata_s[i]  = rand256();
            end
            @(negedge clk);
        end
        gnt_s[i]    = 1'b0;
        rvalid_s[i] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_zero(i);
                for (int k = 0; k < 3; k++) last_line[k] = '0;
                for (int k = 0; k < 2; k++) begin
                    rvalid_s[i] = 1'b1;
                    rdata_s[i]  = rand256();
                    @(negedge clk);
                    chk("late_beat_busy", 256'(busy_s[i]), 256'(0));
                end
                rvalid_s[i] = 1'b0;
                return;
            end
            g = $urandom_range(gmin, gmax);
            for (int k = 0; k < g; k++) begin
                rvalid_s[i] = 1'b0;
                rdata_s[i]  = rand256();
                @(negedge clk);
            end
            gaps += g;
            beat = fixed ? (({64{4'h1}} * 256'(b + 1)) & mask) : (rand256() & mask);
            line |= beat << (b * bw);
            rvalid_s[i] = 1'b1;
            rdata_s[i]  = beat | (rand256() & ~mask);
            if (b == nb - 1) begin
                e.inst = i;
                e.addr = la;
                e.data = line;
                e.cyc  = c0 + 2 + longint'(gwait) + longint'(gaps) + longint'(nb);
                sb.push_back(e);
            end
            @(negedge clk);
        end
        // ACK cycle: a stray extra beat, and optionally the next miss address.
        rvalid_s[i] = 1'($urandom_range(0, 1));
        rdata_s[i]  = rand256();
        if (keep) miss_addr_s[i] = nxt;
        @(negedge clk);
        rvalid_s[i] = 1'b0;
        chk("ack_seen", 256'(sb.size()), 256'(0));
        sb.delete();
        last_line[i] = line;
    endtask

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (ack_s[i]) begin
                if (prev_ack[i]) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_width: inst %0d ack high %0d cycles in a row", i, 2);
                end else if (sb.size() == 0 || sb[0].inst != i) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d got ack, expected none", i);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fill_data", fill_s[i], e.data);
                    chk("ack_addr", 256'(ack_addr_s[i]), 256'(e.addr));
                    chk("ack_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
            prev_ack[i] = ack_s[i];
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            miss_s[i]      = 1'b0;
            miss_addr_s[i] = 32'h0;
            gnt_s[i]       = 1'b0;
            rvalid_s[i]    = 1'b0;
            rdata_s[i]     = '0;
            last_line[i]   = '0;
            prev_ack[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i);
        rst = 1'b0;
        idle_noise(0, 3);

        // Basic minimum-latency fill, then the same line with grant and beat stalls.
        run_fill(0, 32'h0000_1A6C, 0, 0, 0, 1'b1, 1'b0, 32'h0, -1);
        chk("basic_lo", 256'(last_line[0][63:0]), 256'(64'h1111_1111_1111_1111));
        idle_noise(0, 2);
        run_fill(0, 32'h0000_1A6C, 5, 2, 2, 1'b1, 1'b0, 32'h0, -1);

        // Back-to-back: miss held, address redirected during ACK.
        idle_noise(0, 1);
        run_fill(0, 32'h0000_0318, 0, 0, 1, 1'b0, 1'b1, 32'h0000_0120, -1);
        chk("b2b_idle_busy", 256'(busy_s[0]), 256'(0));
        chk("b2b_idle_req",  256'(req_s[0]),  256'(0));
        run_fill(0, 32'h0000_0120, 0, 0, 0, 1'b0, 1'b0, 32'h0, -1);

        // Reset after two beats, then a clean fill.
        idle_noise(0, 1);
        run_fill(0, 32'h0000_2044, 1, 0, 0, 1'b0, 1'b0, 32'h0, 2);
        idle_noise(0, 2);
        run_fill(0, 32'h0000_3000, 0, 0, 0, 1'b0, 1'b0, 32'h0, -1);

        // Narrow and full-width beats with known patterns.
        run_fill(1, 32'h0000_4A7F, 0, 0, 0, 1'b1, 1'b0, 32'h0, -1);
        idle_noise(1, 2);
        run_fill(2, 32'h8000_0005, 0, 0, 0, 1'b1, 1'b0, 32'h0, -1);
        idle_noise(2, 2);

        // Random fills on every width.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 6; n++) begin
                idle_noise(i, $urandom_range(0, 2));
                run_fill(i, $urandom, $urandom_range(0, 3), 0, $urandom_range(0, 2),
                         1'b0, 1'($urandom_range(0, 1)), $urandom, -1);
                if (miss_s[i]) begin
                    run_fill(i, miss_addr_s[i], $urandom_range(0, 2), 0, 1,
                             1'b0, 1'b0, 32'h0, -1);
                end
            end
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
